// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchy node sequencer.
package hier_node_pkg;

  typedef enum logic [0:0] {
    NODE_BCAST = 1'b0,
    NODE_SEQ   = 1'b1
  } node_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } node_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set_idx(input logic [31:0] vec);
    logic found;
    lowest_set_idx = '0;
    found          = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (vec[i] && !found) begin
        lowest_set_idx = 5'(i);
        found          = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/hier_node_sequencer_if.sv
// Parent/child handshake bundle of one hierarchy node.
interface hier_node_sequencer_if #(
  parameter int unsigned NUM_CHILDREN = 5,
  parameter int unsigned IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
);
  logic                    start_i;
  logic [NUM_CHILDREN-1:0] child_mask_i;
  logic [NUM_CHILDREN-1:0] child_done_i;
  logic [NUM_CHILDREN-1:0] child_start_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    error_o;
  logic [IDX_W-1:0]        err_idx_o;

  modport slave (
    input  start_i, child_mask_i, child_done_i,
    output child_start_o, busy_o, done_o, error_o, err_idx_o
  );

  modport master (
    output start_i, child_mask_i, child_done_i,
    input  child_start_o, busy_o, done_o, error_o, err_idx_o
  );
endinterface

// File: rtl/hier_node_timer.sv
// Saturating wait counter; expired marks the enabled cycle in which the count reaches TIMEOUT.
module hier_node_timer #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Counting the current cycle makes TIMEOUT the number of whole WAIT cycles allowed.
  assign expired = en && (cnt >= (LIMIT - 1'b1));

endmodule

// File: rtl/hier_node_sequencer.sv
// Hierarchy node: starts enabled children (broadcast or in index order), gathers their
// completions under a timeout and reports done/error to the parent.
module hier_node_sequencer
  import hier_node_pkg::*;
#(
  parameter int unsigned NUM_CHILDREN = 5,
  parameter int unsigned MODE         = 0,
  parameter int unsigned TIMEOUT_W    = 8,
  parameter int unsigned TIMEOUT      = 200
) (
  input logic                 clk,
  input logic                 rst_n,
  hier_node_sequencer_if.slave bus
);
  localparam int unsigned N     = NUM_CHILDREN;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam bit          SEQ   = (MODE == int'(NODE_SEQ));

  node_state_e      state_q, state_d;
  logic [N-1:0]     mask_q, done_q, done_nxt, pending, missing, awaited, hit, cur_oh;
  logic [IDX_W-1:0] cur_q, sel_idx, miss_idx, err_idx_q;
  logic             error_q, complete, expired;

  hier_node_timer #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == ISSUE),
    .en      (state_q == WAIT),
    .expired (expired)
  );

  always_comb begin
    pending  = mask_q & ~done_q;
    sel_idx  = IDX_W'(lowest_set_idx(32'(pending)));
    cur_oh   = N'(1) << cur_q;
    awaited  = SEQ ? (cur_oh & pending) : pending;
    hit      = (state_q == WAIT) ? (bus.child_done_i & awaited) : '0;
    done_nxt = done_q | hit;
    missing  = mask_q & ~done_nxt;
    miss_idx = IDX_W'(lowest_set_idx(32'(missing)));
    // Sequential completes per child; broadcast only once every enabled child is in.
    complete = SEQ ? (|hit) : (missing == '0);

    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = ISSUE;
      ISSUE:   state_d = (pending == '0) ? FINISH : WAIT;
      WAIT: begin
        if (complete)     state_d = (missing == '0) ? FINISH : ISSUE;
        else if (expired) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      done_q    <= '0;
      cur_q     <= '0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            mask_q    <= bus.child_mask_i;
            done_q    <= '0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
          end
        end
        ISSUE: cur_q <= sel_idx;
        WAIT: begin
          done_q <= done_nxt;
          if (!complete && expired) begin
            error_q   <= 1'b1;
            err_idx_q <= SEQ ? cur_q : miss_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.child_start_o = (state_q == ISSUE)
                           ? (SEQ ? ((N'(1) << sel_idx) & pending) : pending)
                           : '0;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.done_o        = (state_q == FINISH);
  assign bus.error_o       = error_q;
  assign bus.err_idx_o     = err_idx_q;

endmodule
